// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding and port-count limits.
package sdram_arb_pkg;

    localparam int NPORTS_MIN = 2;
    localparam int NPORTS_MAX = 4;
    localparam int GRANT_W    = 2;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selector for the SDRAM arbiter.
// SDRAM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3
)(
    input  logic [NPORTS-1:0]  req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic [GRANT_W-1:0] win_o,
    output logic               any_o
);

    assign any_o = |req_i;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        win_o = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (req_i[i]) win_o = GRANT_W'(i);
    end
`else
    // Winner is the requester at the smallest rotational distance past the last grant.
    always_comb begin
        int d;
        int best;
        d     = 0;
        best  = NPORTS;
        win_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            d = i - int'(last_i) - 1;
            if (d < 0) d = d + NPORTS;
            if (req_i[i] && d < best) begin
                best  = d;
                win_o = GRANT_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port arbiter in front of a single SDRAM controller, one transaction at a time.
// Build option: SDRAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int ADDR_W = 25
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NPORTS-1:0]        p_valid,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*32-1:0]     p_din,
    input  logic [NPORTS*4-1:0]      p_wmask,
    output logic [NPORTS-1:0]        p_ready,
    output logic [31:0]              p_dout,
    output logic                     mem_valid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_din,
    output logic [3:0]               mem_wmask,
    input  logic [31:0]              mem_dout,
    input  logic                     mem_ready,
    output logic [1:0]               grant_id,
    output logic                     busy
);

    state_e state_q, state_d;

    logic               mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic [3:0]         wmask_q, wmask_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [NPORTS-1:0]  p_ready_q, p_ready_d;
    logic [31:0]        p_dout_q, p_dout_d;
    logic               busy_q, busy_d;

    logic [GRANT_W-1:0] win;
    logic               any_req;

    sdram_arb_pick #(.NPORTS(NPORTS)) u_pick (
        .req_i  (p_valid),
        .last_i (grant_q),
        .win_o  (win),
        .any_o  (any_req)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_SYNC;
        else         state_q <= state_d;
    end

    // SYNC soaks up the controller's ready level so a stale ready is never taken as a completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: if (!mem_ready) state_d = ST_IDLE;
            ST_IDLE: if (any_req)    state_d = ST_BUSY;
            ST_BUSY: if (mem_ready)  state_d = ST_DONE;
            ST_DONE:                 state_d = ST_SYNC;
            default:                 state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wmask_d     = wmask_q;
        grant_d     = grant_q;
        p_ready_d   = '0;
        p_dout_d    = p_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d     = win;
                    addr_d      = p_addr[int'(win)*ADDR_W +: ADDR_W];
                    din_d       = p_din[int'(win)*32 +: 32];
                    wmask_d     = p_wmask[int'(win)*4 +: 4];
                    mem_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    p_ready_d   = NPORTS'(1) << grant_q;
                    p_dout_d    = mem_dout;
                end
            end
            default: mem_valid_d = 1'b0;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            wmask_q     <= '0;
            grant_q     <= GRANT_W'(NPORTS - 1);
            p_ready_q   <= '0;
            p_dout_q    <= '0;
            busy_q      <= 1'b1;
        end else begin
            mem_valid_q <= mem_valid_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wmask_q     <= wmask_d;
            grant_q     <= grant_d;
            p_ready_q   <= p_ready_d;
            p_dout_q    <= p_dout_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign mem_wmask = wmask_q;
    assign grant_id  = grant_q;
    assign p_ready   = p_ready_q;
    assign p_dout    = p_dout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with a small SDRAM controller model.
module tb_sdram_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NP-1:0]     p_valid;
    logic [NP*AW-1:0]  p_addr;
    logic [NP*32-1:0]  p_din;
    logic [NP*4-1:0]   p_wmask;
    logic [NP-1:0]     p_ready;
    logic [31:0]       p_dout;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_din;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_dout;
    logic              mem_ready;
    logic [1:0]        grant_id;
    logic              busy;

    logic        ctrl_auto, man_ready, auto_ready;
    logic [31:0] resp_data;
    int          lat_cnt, hold_cnt;
    int          checks = 0;
    int          failures = 0;
    int          grants[$];
    logic        need_low;
    int          viol, multi;

    always #5 clk = ~clk;

    assign mem_ready = ctrl_auto ? auto_ready : man_ready;

    sdram_arbiter #(.NPORTS(NP), .ADDR_W(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_din     (p_din),
        .p_wmask   (p_wmask),
        .p_ready   (p_ready),
        .p_dout    (p_dout),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wmask (mem_wmask),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Controller model: ready after 3 cycles of valid, ready level then held 2 more cycles.
    always @(posedge clk) begin
        #1;
        if (!ctrl_auto) begin
            auto_ready = 1'b0;
            lat_cnt    = 0;
            hold_cnt   = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) auto_ready = 1'b0;
        end else if (!mem_valid) begin
            lat_cnt = 0;
        end else if (!auto_ready) begin
            if (lat_cnt >= 2) begin
                auto_ready = 1'b1;
                mem_dout   = resp_data;
                hold_cnt   = 2;
                lat_cnt    = 0;
            end else begin
                lat_cnt++;
            end
        end
    end

    // Completion log and protocol monitor.
    always @(negedge clk) begin
        if (!resetn) begin
            need_low = 1'b0;
        end else begin
            if ($countones(p_ready) > 1) multi++;
            if (p_ready != '0) begin
                for (int i = 0; i < NP; i++)
                    if (p_ready[i]) grants.push_back(i);
                need_low = 1'b1;
            end else if (!mem_ready) begin
                need_low = 1'b0;
            end
            if (mem_valid && need_low) viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic apply_reset;
        resetn  = 1'b0;
        p_valid = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        int bad = 0;
        int n = 0;
        ctrl_auto = 1'b0; man_ready = 1'b1; resetn = 1'b0;
        p_valid = '0; p_addr = '0; p_din = '0; p_wmask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++;
        if (mem_valid !== 1'b0 || p_ready !== '0) begin
            failures++; $display("FAIL reset_valid: mem_valid=%b p_ready=%b want 0/000", mem_valid, p_ready);
        end
        checks++;
        if (grant_id !== 2'(NP-1)) begin failures++; $display("FAIL reset_grant: got %0d want %0d", grant_id, NP-1); end
        checks++;
        if (p_dout !== '0 || mem_addr !== '0 || mem_din !== '0 || mem_wmask !== '0) begin
            failures++;
            $display("FAIL reset_payload: p_dout=%h addr=%h din=%h wmask=%h want all 0", p_dout, mem_addr, mem_din, mem_wmask);
        end
        resetn = 1'b1;
        p_valid = 3'b001;
        p_addr[0 +: AW] = 25'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL sync_hold: %0d cycles left SYNC or raised mem_valid, want 0", bad); end
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL sync_to_idle: mem_valid=%b busy=%b want 0/0", mem_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 25'h55) begin
            failures++;
            $display("FAIL first_grant: mem_valid=%b grant=%0d addr=%h want 1/0/55", mem_valid, grant_id, mem_addr);
        end
        ctrl_auto = 1'b1;
        p_valid = '0;
        while (p_ready === '0 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (p_ready !== 3'b001) begin failures++; $display("FAIL first_ready: got %b want 001", p_ready); end
        wait_idle();
    endtask

    task automatic test_read;
        int base;
        int n = 0;
        wait_idle();
        base = grants.size();
        resp_data = 32'hDEADBEEF;
        p_addr[1*AW +: AW] = 25'h0000123;
        p_wmask[4 +: 4] = 4'b0000;
        p_valid = 3'b010;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd1 || mem_addr !== 25'h0000123 || mem_wmask !== 4'b0000) begin
            failures++;
            $display("FAIL read_req: valid=%b grant=%0d addr=%h wmask=%b want 1/1/0000123/0000", mem_valid, grant_id, mem_addr, mem_wmask);
        end
        p_valid = '0;
        while (mem_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (p_ready !== 3'b010 || p_dout !== 32'hDEADBEEF) begin
            failures++; $display("FAIL read_resp: p_ready=%b p_dout=%h want 010/deadbeef", p_ready, p_dout);
        end
        @(negedge clk);
        checks++;
        if (p_ready !== '0 || p_dout !== 32'hDEADBEEF) begin
            failures++; $display("FAIL read_hold: p_ready=%b p_dout=%h want 000/deadbeef", p_ready, p_dout);
        end
        wait_idle();
        checks++;
        if (grants.size() != base + 1) begin
            failures++; $display("FAIL read_pulses: got %0d pulses want 1", grants.size() - base);
        end
    endtask

    task automatic test_round_robin;
        int base, v0, exp_g;
        int n = 0;
        apply_reset();
        wait_idle();
        base = grants.size();
        v0 = viol;
        p_wmask = '0;
        p_valid = 3'b111;
        while (grants.size() < base + 6 && n < 400) begin @(negedge clk); n++; end
        p_valid = '0;
        checks++;
        if (grants.size() < base + 6) begin
            failures++; $display("FAIL rr_count: got %0d grants want 6", grants.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                exp_g = 0;
`else
                exp_g = k % 3;
`endif
                checks++;
                if (grants[base + k] != exp_g) begin
                    failures++; $display("FAIL rr_order[%0d]: got port %0d want %0d", k, grants[base + k], exp_g);
                end
            end
        end
        wait_idle();
        checks++;
        if (viol != v0 || multi != 0) begin
            failures++; $display("FAIL rr_protocol: early_valid=%0d multi_ready=%0d want 0/0", viol - v0, multi);
        end
    endtask

    task automatic test_write;
        int bad = 0;
        int n = 0;
        wait_idle();
        resp_data = 32'h0BAD0BAD;
        p_addr[2*AW +: AW] = 25'h1ABCDEF;
        p_din[64 +: 32] = 32'hA5A55A5A;
        p_wmask[8 +: 4] = 4'b0011;
        p_valid = 3'b100;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd2) begin
            failures++; $display("FAIL write_grant: valid=%b grant=%0d want 1/2", mem_valid, grant_id);
        end
        @(negedge clk);
        p_valid = '0;
        p_din[64 +: 32] = 32'h12345678;
        p_wmask[8 +: 4] = 4'b1100;
        p_addr[2*AW +: AW] = '0;
        while (mem_valid === 1'b1 && n < 50) begin
            if (mem_din !== 32'hA5A55A5A || mem_wmask !== 4'b0011 || mem_addr !== 25'h1ABCDEF) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL write_stable: %0d unstable cycles want 0", bad); end
        checks++;
        if (p_ready !== 3'b100) begin failures++; $display("FAIL write_ready: got %b want 100", p_ready); end
        @(negedge clk);
        checks++;
        if (p_ready !== '0) begin failures++; $display("FAIL write_pulse: got %b want 000", p_ready); end
        wait_idle();
    endtask

    task automatic test_reset_busy;
        int base;
        wait_idle();
        base = grants.size();
        p_addr[0 +: AW] = 25'h77;
        p_wmask[0 +: 4] = 4'b0000;
        p_valid = 3'b001;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1) begin failures++; $display("FAIL rb_grant: mem_valid=%b want 1", mem_valid); end
        p_valid = '0;
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b1 || p_ready !== '0 || grant_id !== 2'(NP-1)) begin
            failures++;
            $display("FAIL rb_state: valid=%b busy=%b p_ready=%b grant=%0d want 0/1/000/%0d", mem_valid, busy, p_ready, grant_id, NP-1);
        end
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (grants.size() != base) begin
            failures++; $display("FAIL rb_no_ready: got %0d pulses want 0", grants.size() - base);
        end
    endtask

    task automatic test_back_to_back;
        int base, v0;
        int n = 0;
        int bad = 0;
        wait_idle();
        base = grants.size();
        v0 = viol;
        p_valid = 3'b001;
        while (grants.size() < base + 3 && n < 300) begin @(negedge clk); n++; end
        p_valid = '0;
        wait_idle();
        checks++;
        if (grants.size() != base + 3) begin
            failures++; $display("FAIL b2b_count: got %0d completions want 3", grants.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) if (grants[base + k] != 0) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL b2b_port: %0d completions not on port 0 want 0", bad); end
        end
        checks++;
        if (viol != v0) begin
            failures++; $display("FAIL b2b_ready_low: %0d early mem_valid cycles want 0", viol - v0);
        end
    endtask

    initial begin
        viol = 0; multi = 0; need_low = 1'b0;
        resp_data = '0; mem_dout = '0; auto_ready = 1'b0;
        lat_cnt = 0; hold_cnt = 0;
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
